// File: rtl/buzzer_pkg.sv
// Shared note table, note-period helper, FSM state encoding and note index type.
// Latency: none; elaboration-time constants and types only.
// Backpressure: none.
package buzzer_pkg;

  localparam int NUM_NOTES = 8;

  // Note frequencies in Hz, index 0..7 = C4 D4 E4 F4 G4 A4 B4 C5
  localparam logic [NUM_NOTES-1:0][15:0] NOTE_HZ = {
    16'd523, 16'd494, 16'd440, 16'd392, 16'd349, 16'd330, 16'd294, 16'd262
  };

  typedef logic [2:0] note_idx_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TONE = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  // Square-wave period in clocks for a note, rounded down
  function automatic int note_period(input int clk_hz, input int idx);
    return clk_hz / int'(NOTE_HZ[note_idx_t'(idx)]);
  endfunction

endpackage

// File: rtl/buzzer_tone_osc.sv
// Square-wave oscillator: phase counter plus registered output, high for floor(P/2) of every P cycles.
// Latency: restart gives wave=1 at phase 0 on the next cycle; output is held 0 while not enabled.
// Backpressure: none; it free-runs whenever enabled.
module buzzer_tone_osc #(
  parameter int PH_W = 7
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          en_i,
  input  logic          restart_i,
  input  logic [PH_W:0] period_i,
  output logic          wave_o
);

  logic [PH_W-1:0] phase_q;
  logic [PH_W-1:0] phase_d;
  logic [PH_W-1:0] phase_step;
  logic [PH_W-1:0] last_phase;
  logic [PH_W:0]   half;
  logic            wave_q;
  logic            wave_d;

  // Next phase wraps at P-1; the wave is decided from the phase it will hold next
  always_comb begin
    last_phase = PH_W'(period_i - (PH_W+1)'(1));
    half       = period_i >> 1;
    phase_step = (phase_q == last_phase) ? '0 : phase_q + PH_W'(1);
    phase_d    = '0;
    wave_d     = 1'b0;
    if (restart_i) begin
      // Every beep starts with the high half; P >= 2 so the half is never empty
      phase_d = '0;
      wave_d  = 1'b1;
    end else if (en_i) begin
      phase_d = phase_step;
      wave_d  = ({1'b0, phase_step} < half);
    end
  end

  // Phase counter and output register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      phase_q <= '0;
      wave_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      wave_q  <= wave_d;
    end
  end

  assign wave_o = wave_q;

endmodule

// File: rtl/buzzer_seq.sv
// Eight-note beep sequencer: N beeps of ON/OFF cycles each, or a continuous alarm when N=0.
// Latency: start sampled in IDLE gives busy/BUZZER high the next cycle; done strobes the cycle after the last tone.
// Backpressure: start is ignored while busy; stop aborts from any state on the next cycle with no done.
module buzzer_seq
  import buzzer_pkg::*;
#(
  parameter int CLK_HZ     = 24000000,
  parameter int ON_CYCLES  = 12000000,
  parameter int OFF_CYCLES = 12000000,
  parameter int BEEP_W     = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              start,
  input  logic              stop,
  input  logic [2:0]        note,
  input  logic [BEEP_W-1:0] beeps,
  output logic              BUZZER,
  output logic              busy,
  output logic              done
);

  // C4 is the lowest note, so it sets the longest period
  localparam int P_MAX   = note_period(CLK_HZ, 0);
  localparam int PH_W    = $clog2(P_MAX);
  localparam int PW      = PH_W + 1;
  localparam int DUR_MAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int DUR_W   = $clog2(DUR_MAX + 1);

  state_e            state_q, state_d;
  logic [DUR_W-1:0]  dur_q, dur_d;
  logic [BEEP_W-1:0] beep_q, beep_d;
  note_idx_t         note_q, note_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              osc_en;
  logic              osc_restart;
  logic              tone_last;
  logic              gap_last;
  logic [NUM_NOTES-1:0][PW-1:0] period_tab;
  logic [PW-1:0]     period;

  // Constant period table, one entry per note
  for (genvar g = 0; g < NUM_NOTES; g++) begin : g_period
    assign period_tab[g] = PW'(note_period(CLK_HZ, g));
  end

  // The latched note selects the period, so later note changes cannot disturb a running tone
  assign period    = period_tab[note_q];
  assign tone_last = (dur_q == DUR_W'(ON_CYCLES - 1));
  assign gap_last  = (dur_q == DUR_W'(OFF_CYCLES - 1));

  // Next-state, counter and oscillator control decisions
  always_comb begin
    state_d     = state_q;
    dur_d       = dur_q;
    beep_d      = beep_q;
    note_d      = note_q;
    done_d      = 1'b0;
    osc_en      = 1'b0;
    osc_restart = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // stop wins over a simultaneous start
        if (start && !stop) begin
          state_d     = ST_TONE;
          dur_d       = '0;
          beep_d      = beeps;
          note_d      = note;
          osc_restart = 1'b1;
        end
      end
      ST_TONE: begin
        if (stop) begin
          state_d = ST_IDLE;
          dur_d   = '0;
          beep_d  = '0;
        end else if (tone_last) begin
          dur_d = '0;
          if (beep_q == BEEP_W'(1)) begin
            // Last counted beep: no trailing gap
            state_d = ST_IDLE;
            beep_d  = '0;
            done_d  = 1'b1;
          end else begin
            // A zero count never decrements, which keeps the alarm running
            state_d = ST_GAP;
            if (beep_q != '0) begin
              beep_d = beep_q - BEEP_W'(1);
            end
          end
        end else begin
          dur_d  = dur_q + DUR_W'(1);
          osc_en = 1'b1;
        end
      end
      ST_GAP: begin
        if (stop) begin
          state_d = ST_IDLE;
          dur_d   = '0;
          beep_d  = '0;
        end else if (gap_last) begin
          state_d     = ST_TONE;
          dur_d       = '0;
          osc_restart = 1'b1;
        end else begin
          dur_d = dur_q + DUR_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        dur_d   = '0;
        beep_d  = '0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // FSM state, counters and registered status outputs
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= ST_IDLE;
      dur_q   <= '0;
      beep_q  <= '0;
      note_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dur_q   <= dur_d;
      beep_q  <= beep_d;
      note_q  <= note_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  buzzer_tone_osc #(
    .PH_W(PH_W)
  ) u_osc (
    .clk_i     (CLK),
    .rst_ni    (nRST),
    .en_i      (osc_en),
    .restart_i (osc_restart),
    .period_i  (period),
    .wave_o    (BUZZER)
  );

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_buzzer_seq.sv
// Bench for buzzer_seq: elapsed-time reference model compared every cycle, plus pinned scenario totals.
// Latency: n/a.
// Backpressure: n/a.
module tb_buzzer_seq;

  localparam int CLK_HZ = 26200;
  localparam int ON     = 1000;
  localparam int OFF    = 500;

  logic       CLK = 1'b0;
  logic       nRST = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [2:0] note = 3'd0;
  logic [3:0] beeps = 4'd0;
  logic       BUZZER;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  buzzer_seq #(
    .CLK_HZ     (CLK_HZ),
    .ON_CYCLES  (ON),
    .OFF_CYCLES (OFF),
    .BEEP_W     (4)
  ) dut (
    .CLK    (CLK),
    .nRST   (nRST),
    .start  (start),
    .stop   (stop),
    .note   (note),
    .beeps  (beeps),
    .BUZZER (BUZZER),
    .busy   (busy),
    .done   (done)
  );

  always #5 CLK = ~CLK;

  // Reference model: the sequence is a function of cycles elapsed since the start
  int m_hz [8] = '{262, 294, 330, 349, 392, 440, 494, 523};
  bit m_act = 1'b0;
  int m_e = 0;
  int m_p = 100;
  int m_n = 0;
  int m_pos;
  bit e_buz = 1'b0;
  bit e_busy = 1'b0;
  bit e_done = 1'b0;

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      m_act  = 1'b0;
      e_buz  = 1'b0;
      e_busy = 1'b0;
      e_done = 1'b0;
    end else begin
      e_done = 1'b0;
      if (!m_act) begin
        if (start && !stop) begin
          m_act = 1'b1;
          m_e   = 0;
          m_p   = CLK_HZ / m_hz[note];
          m_n   = int'(beeps);
        end
      end else if (stop) begin
        m_act = 1'b0;
      end else begin
        m_e++;
        if (m_n != 0 && m_e == m_n * ON + (m_n - 1) * OFF) begin
          m_act  = 1'b0;
          e_done = 1'b1;
        end
      end
      m_pos  = m_e % (ON + OFF);
      e_busy = m_act;
      e_buz  = m_act && (m_pos < ON) && ((m_pos % m_p) < (m_p / 2));
    end
  end

  // Every-cycle comparison of the three outputs against the model
  always @(negedge CLK) begin
    checks++;
    if ({BUZZER, busy, done} !== {e_buz, e_busy, e_done}) begin
      errors++;
      $display("FAIL cycle_cmp t=%0t buzzer/busy/done got %b%b%b want %b%b%b",
               $time, BUZZER, busy, done, e_buz, e_busy, e_done);
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  int hi_cnt, busy_cnt, done_cnt, done_k, first_low;

  // Issue a one-cycle start; returns at the negedge of the first cycle after the sampling edge
  task automatic pulse_start(input logic [2:0] n, input logic [3:0] b);
    @(negedge CLK);
    note  = n;
    beeps = b;
    stop  = 1'b0;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
  endtask

  // Observe ncyc cycles counting activity; optional stop and ignored-start injection by cycle index
  task automatic observe(input int ncyc, input int stop_k, input int start_k,
                         input logic [2:0] n2, input logic [3:0] b2);
    hi_cnt = 0; busy_cnt = 0; done_cnt = 0; done_k = 0; first_low = 0;
    for (int k = 1; k <= ncyc; k++) begin
      if (BUZZER) hi_cnt++;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_k = k;
      end
      if (!BUZZER && first_low == 0) first_low = k;
      stop  = (k == stop_k);
      start = (k == start_k);
      if (k == start_k) begin
        note  = n2;
        beeps = b2;
      end
      @(negedge CLK);
    end
    stop  = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    #1;
    chk("reset_buzzer", int'(BUZZER), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    repeat (3) @(negedge CLK);
    nRST = 1'b1;

    // Single C4 beep: P=100
    pulse_start(3'd0, 4'd1);
    observe(1100, 0, 0, 3'd0, 4'd0);
    chk("c4_busy_cycles", busy_cnt, 1000);
    chk("c4_high_cycles", hi_cnt, 500);
    chk("c4_first_low", first_low, 51);
    chk("c4_done_count", done_cnt, 1);
    chk("c4_done_cycle", done_k, 1001);

    // Three A4 beeps: P=59, 29 high / 30 low
    pulse_start(3'd5, 4'd3);
    observe(4100, 0, 0, 3'd0, 4'd0);
    chk("a4_busy_cycles", busy_cnt, 4000);
    chk("a4_high_cycles", hi_cnt, 1479);
    chk("a4_first_low", first_low, 30);
    chk("a4_done_count", done_cnt, 1);

    // Continuous alarm stopped inside the second tone
    pulse_start(3'd0, 4'd0);
    observe(2250, 2200, 0, 3'd0, 4'd0);
    chk("alarm_busy_cycles", busy_cnt, 2200);
    chk("alarm_high_cycles", hi_cnt, 850);
    chk("alarm_done_count", done_cnt, 0);

    // Start with another note while busy is ignored
    pulse_start(3'd2, 4'd2);
    observe(2600, 0, 300, 3'd7, 4'd5);
    chk("ign_busy_cycles", busy_cnt, 2500);
    chk("ign_high_cycles", hi_cnt, 1014);
    chk("ign_first_low", first_low, 40);
    chk("ign_done_count", done_cnt, 1);

    // Start and stop together in IDLE: stays idle
    @(negedge CLK);
    note  = 3'd3;
    beeps = 4'd1;
    start = 1'b1;
    stop  = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    stop  = 1'b0;
    observe(20, 0, 0, 3'd0, 4'd0);
    chk("startstop_busy", busy_cnt, 0);

    // Asynchronous reset in the middle of a tone
    pulse_start(3'd0, 4'd1);
    observe(299, 0, 0, 3'd0, 4'd0);
    chk("pre_reset_busy", int'(busy), 1);
    #1 nRST = 1'b0;
    #1;
    chk("async_rst_outputs", int'({BUZZER, busy, done}), 0);
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
    observe(50, 0, 0, 3'd0, 4'd0);
    chk("post_reset_busy", busy_cnt, 0);
    chk("post_reset_done", done_cnt, 0);

    // Randomized sequences with jittered inputs, spurious starts and random aborts
    for (int s = 0; s < 12; s++) begin
      int nb;
      int stop_at;
      int k;
      nb = $urandom_range(0, 3);
      if (nb == 0) stop_at = $urandom_range(100, 3500);
      else if ($urandom_range(0, 2) == 0) stop_at = $urandom_range(1, 4500);
      else stop_at = 0;
      pulse_start(3'($urandom_range(0, 7)), 4'(nb));
      k = 1;
      while (busy && k < 6000) begin
        start = ($urandom_range(0, 199) == 0);
        note  = 3'($urandom);
        beeps = 4'($urandom);
        stop  = (k == stop_at);
        @(negedge CLK);
        k++;
      end
      start = 1'b0;
      stop  = 1'b0;
      chk("rand_seq_ends", int'(busy), 0);
      repeat ($urandom_range(1, 5)) @(negedge CLK);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/buzzer_seq.md
Name: buzzer_seq

Overview:
- Parametrised successor to the single-note beeper: an 8-note square-wave tone sequencer for the piezo buzzer.
- A start pulse plays N beeps of a selected note with programmable on/gap timing; N=0 is a continuous alarm until stop.
- Sits between the clock/alarm control FSM and the BUZZER pin. Reports busy and a one-cycle done strobe.

Parameters:
- CLK_HZ, 24000000, system clock frequency; must be >= 1046 so every note period is >= 2 cycles.
- ON_CYCLES, 12000000, tone length of one beep in clocks (500 ms at 24 MHz); must be >= 1.
- OFF_CYCLES, 12000000, silent gap between beeps in clocks; must be >= 1.
- BEEP_W, 4, width of the beep-count input.

Ports:
- CLK, input, 1, system clock, rising edge.
- nRST, input, 1, asynchronous active-low reset.
- start, input, 1, request pulse; sampled only in IDLE.
- stop, input, 1, abort; sampled in every state.
- note, input, 3, note index 0..7 = C4 D4 E4 F4 G4 A4 B4 C5 (262 294 330 349 392 440 494 523 Hz).
- beeps, input, BEEP_W, number of beeps; 0 selects continuous alarm mode.
- BUZZER, output, 1, registered square wave to the piezo.
- busy, output, 1, high while in TONE or GAP.
- done, output, 1, one-cycle strobe when a counted sequence completes normally.

Behaviour:
- Reset (async, nRST=0): state IDLE; BUZZER=0, busy=0, done=0; all counters 0.
- States: IDLE, TONE, GAP. done is a registered strobe, not a state.
- Note period P = floor(CLK_HZ / f_note), taken from a constant table. High half H = floor(P/2); low half = P-H.
- IDLE, start=1, stop=0, edge t:
  - Latch note, P and beeps.
  - From cycle t+1: state TONE, busy=1, BUZZER=1, phase=0, beep counter = beeps.
- TONE:
  - phase increments each cycle and wraps from P-1 to 0.
  - BUZZER=1 while phase<H, 0 otherwise (registered, aligned with phase). Every beep starts at phase 0 with a high half.
  - Duration counter runs for exactly ON_CYCLES cycles. The tone may end mid-period, and BUZZER then drops to 0.
- End of TONE:
  - Counted mode, last beep: go to IDLE. busy=0 and done=1 in the same next cycle; no trailing gap.
  - Otherwise: go to GAP for exactly OFF_CYCLES cycles with BUZZER=0, then back to TONE with phase reset.
- Counted mode: busy lasts exactly N*ON_CYCLES + (N-1)*OFF_CYCLES cycles.
- Continuous mode (beeps=0): TONE/GAP alternate indefinitely; done never asserts.
- stop=1 in TONE or GAP: next cycle IDLE, BUZZER=0, busy=0, done=0 (abort gives no done).
- start while busy: ignored; latched note and count are unchanged.
- start and stop together in IDLE: stop wins, the block stays IDLE.
- Changes to note or beeps while busy: no effect.
- nRST asserted mid-sequence: immediate return to reset values; no done.
- Widths:
  - Phase counter: $clog2(max P).
  - Duration counter: $clog2(max(ON_CYCLES, OFF_CYCLES)+1).
  - Beep counter: BEEP_W.
  - All compares are exact equality on terminal counts; no overflow is possible.

Decomposition:
- Shared package buzzer_pkg holds:
  - The note frequency constants (NOTE_HZ[0..7]).
  - A constant function note_period(clk_hz, idx).
  - The state encoding (IDLE/TONE/GAP).
  - The note-index type.
- One sub-module, buzzer_tone_osc:
  - Inputs: clock, reset, enable, restart, period.
  - Owns the phase counter and the registered square-wave output.
  - Holds the output at 0 when not enabled.
- buzzer_seq keeps the FSM, the duration counter and the beep counter.

Test Plan:
- Bench config for all scenarios: CLK_HZ=26200, ON_CYCLES=1000, OFF_CYCLES=500.
- Reset mid-TONE (nRST low at cycle 300) -> BUZZER, busy and done all 0 asynchronously; after release the block idles until the next start.
- start, note=0, beeps=1 at edge t -> busy high for cycles t+1..t+1000. BUZZER is 50 high/50 low (P=100) for 10 full periods. done=1 only at t+1001.
- note=5 (A4), beeps=3 -> P=59, BUZZER 29 high/30 low. Busy for 3*1000+2*500=4000 cycles. BUZZER=0 through both gaps. Exactly one done strobe.
- beeps=0 (continuous), stop at cycle 2200 -> tone/gap alternate; stop falls in the second tone. Next cycle BUZZER=0, busy=0, no done.
- start with note=7 during a beeps=2 run; also start and stop together in IDLE -> the first is ignored and the note stays unchanged. With the simultaneous pair, busy stays 0.
